display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit slot is shown; legal range 2 or more.
REQ-002 Parameter BLINK_DIV, default 12500000: clk cycles per blink half-period; legal range 2 or more.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: 1 = scan and drive the display; 0 = display dark and counters frozen.
REQ-006 Port digits_in, input, 24: six BCD nibbles; [3:0] = seconds units, [7:4] = seconds tens, [11:8] = minutes units, [15:12] = minutes tens, [19:16] = hours units, [23:20] = hours tens.
REQ-007 Port blink_mask, input, 6: bit i = 1 makes digit i blink (set mode).
REQ-008 Port lz_en, input, 1: 1 = blank the hours-tens digit when its value is 0.
REQ-009 Port bcd_out, output, 4: nibble sent to the shared BCD-to-7-segment decoder.
REQ-010 Port seg_in, input, 7: decoder output, active-low, same bit order as seg_out.
REQ-011 Port seg_out, output, 7: registered segment drive, active-low; 7'b1111111 = blank.
REQ-012 Port digit_sel, output, 6: registered anode select, active-low; bit i enables digit i.

Function
REQ-013 Prescaler: pcnt counts 0..SCAN_DIV-1 while enable=1; slot tick is asserted when pcnt=SCAN_DIV-1; after that value pcnt wraps to 0.
REQ-014 Digit index: idx (0..5) increments on each slot tick; after 5 it wraps to 0; it holds otherwise.
REQ-015 bcd_out: combinational; equals digits_in[4*idx+3:4*idx] from the registered idx. Values above 9 pass through unmodified; the decoder blanks them.
REQ-016 Blink: bcnt counts 0..BLINK_DIV-1 while enable=1. When bcnt=BLINK_DIV-1, bcnt wraps to 0 and the phase bit toggles.
REQ-017 Blank condition for the current slot: (blink_mask[idx]=1 and phase=1), or (lz_en=1 and idx=5 and digits_in[23:20]=0).
REQ-018 Output register, every cycle with enable=1: seg_out <= blank condition ? 7'b1111111 : seg_in; digit_sel <= all ones except bit idx = 0.
  - Result: exactly one cycle of latency from an idx change to the matching seg_out/digit_sel.
  - seg_out and digit_sel always change on the same edge.
REQ-019 Invariant: digit_sel has at most one bit at 0 in every cycle.
REQ-020 enable=0:
  - next edge: digit_sel <= 6'b111111 and seg_out <= 7'b1111111;
  - pcnt, idx, bcnt and phase hold their values.
REQ-021 enable returning to 1: scanning resumes from the held counters; the first lit output appears on the following edge.
REQ-022 Input changes: a change to digits_in, blink_mask or lz_en mid-slot appears on seg_out on the next edge; no retiming beyond the output register.
REQ-023 Simultaneous events: a slot tick and a blink terminal count in the same cycle both take effect; the blank condition for the new idx uses the new phase from the next cycle onward.

Reset
REQ-024 reset=1 at a rising edge forces pcnt=0, idx=0, bcnt=0, phase=0, digit_sel=6'b111111 and seg_out=7'b1111111, regardless of enable.
REQ-025 Reset asserted mid-slot or mid-blink discards all partial counts; there is no partial-slot carry-over.
REQ-026 First cycle after reset release with enable=1: digit_sel=6'b111110 and seg_out=seg_in for digits_in[3:0].

Verification
Benches run with SCAN_DIV=4 and BLINK_DIV=16.
REQ-027 Scan order:
  - stimulus: reset, then enable=1, digits_in=24'h123456, blink_mask=0, lz_en=0;
  - response: bcd_out = 6,5,4,3,2,1,6 with each value held 4 cycles; digit_sel steps 111110 to 011111, then wraps; one cycle of lag vs bcd_out.
REQ-028 Blink:
  - stimulus: blink_mask=6'b000001;
  - response: digit 0 slot shows seg_out=7'b1111111 during the 16-cycle windows with phase=1 and decoded segments when phase=0; other digits are never blanked.
REQ-029 Leading zero:
  - stimulus: digits_in[23:20]=0, lz_en=1;
  - response: slot idx=5 gives seg_out=7'b1111111 with digit_sel=6'b011111.
  - stimulus: lz_en=0;
  - response: seg_out = seg_in for 0.
REQ-030 Enable drop:
  - stimulus: enable=0 for 10 cycles in the middle of slot idx=2 with pcnt=1;
  - response: display dark on the next edge; after enable=1, idx=2 resumes with pcnt continuing from 1.
REQ-031 Reset mid-operation:
  - stimulus: reset pulse at idx=4, phase=1;
  - response: next edge gives all outputs blank and counters 0; after release, the idx=0 slot lasts the full 4 cycles.
REQ-032 Invariant check: across all scenarios, an assertion confirms digit_sel never has two or more bits at 0.

Source files
------------

// File: rtl/display_scanner.sv
`timescale 1ns / 1ps
// display_scanner: time-multiplexed driver for a six-digit 7-segment clock display.
// A prescaler steps a digit index once every SCAN_DIV cycles. The selected BCD nibble goes
// out to a shared external decoder, and the decoded segments come back in. They are
// registered together with the anode select, so seg_out and digit_sel always change
// together. A second counter makes a blink phase for set mode, and the hours-tens digit
// can be blanked when it holds a leading zero.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   enable     - 1 = scan and drive; 0 = dark display with frozen counters
//   digits_in  - six BCD nibbles, [3:0] = seconds units ... [23:20] = hours tens
//   blink_mask - bit i = 1 makes digit i blink
//   lz_en      - blank the hours-tens digit when it is 0
//   bcd_out    - nibble for the current slot (combinational from the registered index)
//   seg_in     - decoder result for bcd_out, active-low
//   seg_out    - registered segment drive, active-low, all ones = blank
//   digit_sel  - registered anode select, active-low, at most one bit low
module display_scanner #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] digits_in,
  input  logic [5:0]  blink_mask,
  input  logic        lz_en,
  output logic [3:0]  bcd_out,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_out,
  output logic [5:0]  digit_sel
);

  localparam int unsigned PcntW = $clog2(SCAN_DIV);
  localparam int unsigned BcntW = $clog2(BLINK_DIV);
  localparam logic [PcntW-1:0] PcntMax = PcntW'(SCAN_DIV - 1);
  localparam logic [BcntW-1:0] BcntMax = BcntW'(BLINK_DIV - 1);
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [5:0] SelNone  = 6'b111111;

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;

  logic       slot_tick, blink_tc, blank;
  logic [5:0] sel_cur;
  logic       mask_bit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= 3'd0;
      phase_q <= 1'b0;
      seg_q   <= SegBlank;
      sel_q   <= SelNone;
    end else begin
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  // Slot decode from the registered index; indices 6 and 7 cannot occur
  always_comb begin
    bcd_out  = 4'h0;
    sel_cur  = SelNone;
    mask_bit = 1'b0;
    unique case (idx_q)
      3'd0: begin bcd_out = digits_in[3:0];   sel_cur = 6'b111110; mask_bit = blink_mask[0]; end
      3'd1: begin bcd_out = digits_in[7:4];   sel_cur = 6'b111101; mask_bit = blink_mask[1]; end
      3'd2: begin bcd_out = digits_in[11:8];  sel_cur = 6'b111011; mask_bit = blink_mask[2]; end
      3'd3: begin bcd_out = digits_in[15:12]; sel_cur = 6'b110111; mask_bit = blink_mask[3]; end
      3'd4: begin bcd_out = digits_in[19:16]; sel_cur = 6'b101111; mask_bit = blink_mask[4]; end
      3'd5: begin bcd_out = digits_in[23:20]; sel_cur = 6'b011111; mask_bit = blink_mask[5]; end
      default: begin bcd_out = 4'h0; sel_cur = SelNone; mask_bit = 1'b0; end
    endcase
  end

  // Blanking uses the current phase, so a phase flip coinciding with a slot tick
  // only affects the new slot from the cycle after the flip.
  always_comb begin
    blank = (mask_bit & phase_q) | (lz_en & (idx_q == 3'd5) & (digits_in[23:20] == 4'h0));
  end

  // Next-state logic
  always_comb begin
    slot_tick = (pcnt_q == PcntMax);
    blink_tc  = (bcnt_q == BcntMax);
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    seg_d     = SegBlank;
    sel_d     = SelNone;
    if (enable) begin
      pcnt_d = slot_tick ? '0 : pcnt_q + 1'b1;
      if (slot_tick) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      bcnt_d = blink_tc ? '0 : bcnt_q + 1'b1;
      if (blink_tc) begin
        phase_d = ~phase_q;
      end
      seg_d = blank ? SegBlank : seg_in;
      sel_d = sel_cur;
    end
  end

  // Outputs
  always_comb begin
    seg_out   = seg_q;
    digit_sel = sel_q;
  end

endmodule
